cmplx_mac_sm: RTL
=================

CMPLX_MAC_SM -- requirements
Module: cmplx_mac_sm

Interface
REQ-001 SHALL have parameter WIDTH, default 8: signed two's-complement operand and result word width.
REQ-002 SHALL have parameter DEPTH, default 4: number of complex products accumulated per result (1..16).
REQ-003 SHALL have parameter SHIFT, default 0: arithmetic right shift applied to the accumulator before output.
REQ-004 SHALL have port clk  input  1: single clock.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port handshake  input  1: asynchronous level (switch); each rising edge advances the machine by one step.
REQ-007 SHALL have port data_in  input  WIDTH: operand word, sampled on a handshake step.
REQ-008 SHALL have port led  output  WIDTH: result display word.
REQ-009 SHALL have port res_valid  output  1: high while a result is displayed.
REQ-010 SHALL have port res_is_im  output  1: high when led carries the imaginary part.
REQ-011 SHALL have port term_cnt  output  $clog2(DEPTH)+1: number of products accumulated so far.

Function
REQ-012 SHALL pass handshake through a 2-flop synchroniser plus a delay flop; step = sync2 & ~sync3, one clk pulse per rising edge, however long the level is held.
REQ-013 SHALL sample data_in on the clk where step is high; data_in is stable from before the handshake edge until 3 clk after it.
REQ-014 SHALL implement states LD_RE_A -> LD_IM_A -> LD_RE_Q -> LD_IM_Q, each advancing on step and registering its word.
REQ-015 SHALL enter MAC on the step leaving LD_IM_Q, stay exactly one clk, add re=ra*rq-ia*iq and im=ra*iq+ia*rq to the accumulators, and increment term_cnt.
REQ-016 SHALL leave MAC to LD_RE_A if term_cnt (after increment) < DEPTH, else to SHOW_RE.
REQ-017 SHALL in SHOW_RE drive led = scaled real result, res_valid=1, res_is_im=0; step -> SHOW_IM.
REQ-018 SHALL in SHOW_IM drive led = scaled imaginary result, res_valid=1, res_is_im=1; step -> LD_RE_A with both accumulators and term_cnt cleared in the same clk.
REQ-019 SHALL use full-precision accumulators of 2*WIDTH+1+$clog2(DEPTH) bits, never overflowing internally.
REQ-020 SHALL form the scaled result as accumulator >>> SHIFT (arithmetic), then reduce to WIDTH per REQ-024.
REQ-021 SHALL drive led=0, res_valid=0 and res_is_im=0 in every state other than SHOW_RE/SHOW_IM.
REQ-022 SHALL ignore steps while in MAC (unreachable at legal switch rates; must not corrupt state).

Reset
REQ-023 SHALL on reset, at any state including mid-load or mid-display, go to LD_RE_A and clear operand registers, accumulators, term_cnt and synchroniser flops; led=0, res_valid=0, res_is_im=0 from the next clk.

Configuration
REQ-024 SHALL, with CMPLX_MAC_SAT_EN defined, saturate the scaled result to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; without it, keep the low WIDTH bits (wrap).

Structure
REQ-025 SHALL take the state enum (LD_RE_A, LD_IM_A, LD_RE_Q, LD_IM_Q, MAC, SHOW_RE, SHOW_IM) and a cmplx_t struct {re, im} parametrised by WIDTH from shared package cmplx_pkg.
REQ-026 SHALL place synchroniser plus edge detect in sub-module handshake_sync (ports clk, reset, async_in, step).

Verification (WIDTH=8)
REQ-027 SHALL cover DEPTH=1, SHIFT=0: a=(3,2), q=(1,4) -> SHOW_RE led=8'hFB (-5), SHOW_IM led=8'h0E (14).
REQ-028 SHALL cover DEPTH=2: (1,1)*(1,1) then (2,0)*(3,-1) -> led 8'h06 then 8'h00; term_cnt reads 1 after the first MAC, 2 at SHOW_RE.
REQ-029 SHALL cover DEPTH=1, SHIFT=0: a=(100,0), q=(100,0) -> real led=8'h10 without CMPLX_MAC_SAT_EN, 8'h7F with it.
REQ-030 SHALL cover DEPTH=1, SHIFT=7: a=(-128,0), q=(-128,0) -> real led=8'h80 without the macro, 8'h7F with it.
REQ-031 SHALL cover handshake held high for 50 clk -> exactly one state advance.
REQ-032 SHALL cover reset asserted in LD_RE_Q and again in SHOW_IM -> LD_RE_A, led=0, term_cnt=0; the next full sequence yields correct results.

Source files
------------

// File: rtl/cmplx_pkg.sv
// Shared types for the complex multiply-accumulate step machine:
// the controller state encoding, a complex operand record and a helper
// that sizes the full-precision accumulator.
package cmplx_pkg;

    // Storage width of each cmplx_t field. Operands of any WIDTH up to this
    // value are held sign-extended, so arithmetic on the fields is exact.
    localparam int CMPLX_MAX_W = 32;

    typedef enum logic [2:0] {
        LD_RE_A,
        LD_IM_A,
        LD_RE_Q,
        LD_IM_Q,
        MAC,
        SHOW_RE,
        SHOW_IM
    } state_t;

    typedef struct packed {
        logic signed [CMPLX_MAX_W-1:0] re;
        logic signed [CMPLX_MAX_W-1:0] im;
    } cmplx_t;

    // Two WIDTH x WIDTH products summed need 2*WIDTH+1 bits; DEPTH terms
    // add $clog2(DEPTH) more so the accumulator can never overflow.
    function automatic int acc_width(input int width, input int depth);
        return 2 * width + 1 + $clog2(depth);
    endfunction

endpackage

// File: rtl/cmplx_mac_sm_handshake_sync.sv
// Brings the asynchronous handshake switch into the clk domain and turns
// each rising edge into a single-cycle step pulse, however long it is held.
module handshake_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic step
);

    logic sync1_q;
    logic sync2_q;
    logic sync3_q;

    // Two-flop synchroniser followed by a delay flop for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= async_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign step = sync2_q & ~sync3_q;

endmodule

// File: rtl/cmplx_mac_sm.sv
// Complex multiply-accumulate driven by a manual handshake switch.
// Four steps load a = (re, im) and q = (re, im); one MAC cycle adds a*q to
// the accumulators; after DEPTH products the scaled real and imaginary
// results are shown on led, one step each.
// Build option: define CMPLX_MAC_SAT_EN to saturate the scaled result to
// WIDTH bits instead of wrapping. Operand WIDTH is limited to 32.
module cmplx_mac_sm
    import cmplx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int SHIFT = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      handshake,
    input  logic [WIDTH-1:0]          data_in,
    output logic [WIDTH-1:0]          led,
    output logic                      res_valid,
    output logic                      res_is_im,
    output logic [$clog2(DEPTH):0]    term_cnt
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ACC_W = acc_width(WIDTH, DEPTH);

    logic                      step;
    state_t                    state_q, state_d;
    cmplx_t                    a_q, a_d;
    cmplx_t                    q_q, q_d;
    logic signed [ACC_W-1:0]   acc_re_q, acc_re_d;
    logic signed [ACC_W-1:0]   acc_im_q, acc_im_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [CNT_W-1:0]          cnt_inc;
    logic signed [CMPLX_MAX_W-1:0] din_ext;
    logic signed [ACC_W-1:0]   prod_re, prod_im;
    logic [WIDTH-1:0]          re_out, im_out;

    handshake_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (handshake),
        .step     (step)
    );

    assign din_ext  = CMPLX_MAX_W'(signed'(data_in));
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign term_cnt = cnt_q;

    // Operands are stored sign-extended, so evaluating at the wider of the
    // field and accumulator widths yields the exact complex product terms.
    assign prod_re = ACC_W'(a_q.re * q_q.re - a_q.im * q_q.im);
    assign prod_im = ACC_W'(a_q.re * q_q.im + a_q.im * q_q.re);

`ifdef CMPLX_MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    function automatic logic [WIDTH-1:0] reduce(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] s;
        s = v >>> SHIFT;
        if (s > SAT_MAX) begin
            return {1'b0, {(WIDTH-1){1'b1}}};
        end else if (s < SAT_MIN) begin
            return {1'b1, {(WIDTH-1){1'b0}}};
        end
        return s[WIDTH-1:0];
    endfunction

    assign re_out = reduce(acc_re_q);
    assign im_out = reduce(acc_im_q);
`else
    assign re_out = WIDTH'(acc_re_q >>> SHIFT);
    assign im_out = WIDTH'(acc_im_q >>> SHIFT);
`endif

    // State, operand, accumulator and term-count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= LD_RE_A;
            a_q      <= '0;
            q_q      <= '0;
            acc_re_q <= '0;
            acc_im_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            q_q      <= q_d;
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state, datapath updates and display outputs.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        acc_re_d  = acc_re_q;
        acc_im_d  = acc_im_q;
        cnt_d     = cnt_q;
        led       = '0;
        res_valid = 1'b0;
        res_is_im = 1'b0;
        case (state_q)
            LD_RE_A: begin
                if (step) begin
                    a_d.re  = din_ext;
                    state_d = LD_IM_A;
                end
            end
            LD_IM_A: begin
                if (step) begin
                    a_d.im  = din_ext;
                    state_d = LD_RE_Q;
                end
            end
            LD_RE_Q: begin
                if (step) begin
                    q_d.re  = din_ext;
                    state_d = LD_IM_Q;
                end
            end
            LD_IM_Q: begin
                if (step) begin
                    q_d.im  = din_ext;
                    state_d = MAC;
                end
            end
            MAC: begin
                // Single cycle; a step arriving here is deliberately dropped.
                acc_re_d = acc_re_q + prod_re;
                acc_im_d = acc_im_q + prod_im;
                cnt_d    = cnt_inc;
                state_d  = (cnt_inc < CNT_W'(DEPTH)) ? LD_RE_A : SHOW_RE;
            end
            SHOW_RE: begin
                led       = re_out;
                res_valid = 1'b1;
                if (step) begin
                    state_d = SHOW_IM;
                end
            end
            SHOW_IM: begin
                led       = im_out;
                res_valid = 1'b1;
                res_is_im = 1'b1;
                if (step) begin
                    acc_re_d = '0;
                    acc_im_d = '0;
                    cnt_d    = '0;
                    state_d  = LD_RE_A;
                end
            end
            default: begin
                state_d = LD_RE_A;
            end
        endcase
    end

endmodule
